// File: rtl/fft_input_sequencer.sv
// fft_input_sequencer
//   Captures one N_PT-sample frame from both ADC channels at once. It then
//   feeds two forward transforms through the shared FFT core: channel 1
//   first, then channel 2. En_FFT1 is held steady through each unload so
//   the FFT results land in the matching RAM.
//
// Ports
//   clk_FFT, rst_n          : clock, asynchronous active-low reset
//   capture_go              : one-cycle request to capture/process a frame
//   adc_valid, adc1/2_data  : simultaneous sample strobe and samples
//   fft_rfd, fft_dv         : FFT core ready-for-data / output-valid
//   start_FFT               : one-cycle transform start pulse
//   FFT_xn_re               : sample presented to the core
//   En_FFT1                 : 1 = channel-1 transform/unload, 0 = channel 2
//   busy                    : high outside IDLE
//   frame_done              : one-cycle pulse after the second unload
//   err                     : sticky timeout / request-while-busy flag
module fft_input_sequencer #(
    parameter int N_PT  = 256,
    parameter int AW    = 8,
    parameter int ADC_W = 14,
    parameter int TMO   = 4096
) (
    input  logic             clk_FFT,
    input  logic             rst_n,
    input  logic             capture_go,
    input  logic             adc_valid,
    input  logic [ADC_W-1:0] adc1_data,
    input  logic [ADC_W-1:0] adc2_data,
    input  logic             fft_rfd,
    input  logic             fft_dv,
    output logic             start_FFT,
    output logic [ADC_W-1:0] FFT_xn_re,
    output logic             En_FFT1,
    output logic             busy,
    output logic             frame_done,
    output logic             err
);

    localparam int TW = $clog2(TMO + 1);

    typedef enum logic [3:0] {
        IDLE, CAPTURE, START1, LOAD1, WAIT1, START2, LOAD2, WAIT2, DONE
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    wr_idx_q, wr_idx_d;
    logic [AW-1:0]    rd_idx_q, rd_idx_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             dv_seen_q, dv_seen_d;
    logic             start_q, start_d;
    logic [ADC_W-1:0] xn_q, xn_d;
    logic             en_q, en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [ADC_W-1:0] buf1 [N_PT];
    logic [ADC_W-1:0] buf2 [N_PT];
    logic             buf_we;
    logic [AW-1:0]    rd_nxt;

    // Frame buffers carry no reset; their contents are only read after a
    // complete capture.
    always_ff @(posedge clk_FFT) begin
        if (buf_we) begin
            buf1[wr_idx_q] <= adc1_data;
            buf2[wr_idx_q] <= adc2_data;
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_idx_d  = wr_idx_q;
        rd_idx_d  = rd_idx_q;
        tmo_d     = tmo_q;
        dv_seen_d = dv_seen_q;
        start_d   = 1'b0;
        xn_d      = xn_q;
        en_d      = en_q;
        done_d    = 1'b0;
        err_d     = err_q;
        buf_we    = 1'b0;
        rd_nxt    = rd_idx_q + AW'(1);

        case (state_q)
            IDLE: begin
                if (capture_go) begin
                    state_d  = CAPTURE;
                    wr_idx_d = '0;
                    err_d    = 1'b0;
                end
            end
            CAPTURE: begin
                if (adc_valid) begin
                    buf_we   = 1'b1;
                    wr_idx_d = wr_idx_q + AW'(1);
                    if (wr_idx_q == AW'(N_PT - 1)) begin
                        state_d = START1;
                        start_d = 1'b1;
                        en_d    = 1'b1;
                    end
                end
            end
            // The first sample is prefetched here. It then sits on
            // FFT_xn_re for the first accept cycle, so the buffer read
            // never stalls the core.
            START1: begin
                state_d  = LOAD1;
                rd_idx_d = '0;
                xn_d     = buf1[0];
            end
            START2: begin
                state_d  = LOAD2;
                rd_idx_d = '0;
                xn_d     = buf2[0];
            end
            // On each accept, the next sample is loaded for the following
            // accept. After the last accept, the value is held.
            LOAD1, LOAD2: begin
                if (fft_rfd) begin
                    if (rd_idx_q == AW'(N_PT - 1)) begin
                        state_d   = (state_q == LOAD1) ? WAIT1 : WAIT2;
                        tmo_d     = '0;
                        dv_seen_d = 1'b0;
                    end else begin
                        rd_idx_d = rd_nxt;
                        xn_d     = (state_q == LOAD1) ? buf1[rd_nxt] : buf2[rd_nxt];
                    end
                end
            end
            // dv seen high at any point, including the first WAIT cycle,
            // arms the wait. The first low cycle after that is the falling
            // edge. Completion wins over a same-cycle timeout.
            WAIT1, WAIT2: begin
                tmo_d = tmo_q + TW'(1);
                if (fft_dv) dv_seen_d = 1'b1;
                if (dv_seen_q && !fft_dv) begin
                    if (state_q == WAIT1) begin
                        state_d = START2;
                        start_d = 1'b1;
                        en_d    = 1'b0;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        en_d    = 1'b1;
                    end
                end else if (tmo_q == TW'(TMO - 1)) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    en_d    = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A request outside IDLE (DONE included) is refused and flagged.
        if (capture_go && state_q != IDLE) err_d = 1'b1;

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_FFT or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wr_idx_q  <= '0;
            rd_idx_q  <= '0;
            tmo_q     <= '0;
            dv_seen_q <= 1'b0;
            start_q   <= 1'b0;
            xn_q      <= '0;
            en_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_idx_q  <= wr_idx_d;
            rd_idx_q  <= rd_idx_d;
            tmo_q     <= tmo_d;
            dv_seen_q <= dv_seen_d;
            start_q   <= start_d;
            xn_q      <= xn_d;
            en_q      <= en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign start_FFT  = start_q;
    assign FFT_xn_re  = xn_q;
    assign En_FFT1    = en_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign err        = err_q;

endmodule

// File: doc/fft_input_sequencer.md
Name: fft_input_sequencer

Overview:
- Upstream feeder for the FFT result stage.
- Captures one N-point frame from each of the two ADC channels simultaneously into internal buffers.
- Runs two back-to-back forward FFTs through the shared FFT core: channel 1 first, then channel 2.
- Drives start_FFT, FFT_xn_re and En_FFT1, holding En_FFT1 stable through each unload so results land in the correct FFT RAM (En_FFT1=1 selects RAM1, En_FFT1=0 selects RAM2).

Parameters:
- N_PT, 256, points per frame; must be a power of two.
- AW, 8, log2(N_PT); width of capture and feed indices.
- ADC_W, 14, ADC sample width; equals the FFT xn_re width.
- TMO, 4096, clk_FFT cycles allowed in a WAIT state before timeout.

Ports:
- clk_FFT  in  1  sole clock (FFT clock domain)
- rst_n  in  1  asynchronous, active-low reset
- capture_go  in  1  one-cycle request to capture and process a frame
- adc_valid  in  1  sample strobe; both channels are sampled together
- adc1_data  in  ADC_W  channel 1 sample, two's complement
- adc2_data  in  ADC_W  channel 2 sample, two's complement
- fft_rfd  in  1  FFT core ready-for-data
- fft_dv  in  1  FFT core output data valid
- start_FFT  out  1  one-cycle FFT start pulse
- FFT_xn_re  out  ADC_W  sample presented to the FFT core
- En_FFT1  out  1  1 = current transform/unload is channel 1, 0 = channel 2
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse when both transforms have unloaded
- err  out  1  sticky; set on timeout or on capture_go while busy

Behaviour:
- Reset, asynchronous on rst_n=0:
  - state=IDLE; indices=0; timeout counter=0.
  - start_FFT=0, FFT_xn_re=0, En_FFT1=1, busy=0, frame_done=0, err=0.
  - Reset mid-frame aborts immediately; buffer contents are don't-care.
- All outputs are registered.
- States: IDLE, CAPTURE, START1, LOAD1, WAIT1, START2, LOAD2, WAIT2, DONE.
- IDLE:
  - capture_go=1 -> CAPTURE, wr_idx=0, err cleared.
  - adc_valid is ignored in IDLE.
- CAPTURE:
  - Each adc_valid=1 cycle writes adc1_data and adc2_data to buf1[wr_idx] and buf2[wr_idx], then wr_idx+1.
  - The write at wr_idx=N_PT-1 -> START1. wr_idx wraps to 0 and is not used further.
- START1: En_FFT1=1, start_FFT=1 for exactly this one cycle -> LOAD1, rd_idx=0.
- LOAD1:
  - Each cycle with fft_rfd=1 is an accept cycle.
  - During the k-th accept cycle (k=0..N_PT-1), FFT_xn_re=buf1[k]. Buffer read latency is hidden by prefetch.
  - Cycles with fft_rfd=0 hold FFT_xn_re and rd_idx.
  - After accept N_PT-1 -> WAIT1. FFT_xn_re is then held at its last value.
- WAIT1:
  - En_FFT1 stays 1.
  - Wait for fft_dv rising and then falling; on the falling edge -> START2.
  - The timeout counter runs only in WAIT states. If it reaches TMO -> err=1, state IDLE, En_FFT1=1, no frame_done.
- START2 / LOAD2 / WAIT2: identical to START1 / LOAD1 / WAIT1 with En_FFT1=0 and buf2.
  - En_FFT1 changes only on entry to START2, and returns to 1 on entry to DONE.
  - The WAIT2 falling edge of fft_dv -> DONE.
- DONE: frame_done=1 for one cycle -> IDLE.
- capture_go while busy=1: ignored and err=1. The frame in progress is not disturbed.
- capture_go in the same cycle as the DONE -> IDLE transition is treated as busy (rule above applies).
- A new frame may start on the cycle after the DONE cycle.
- fft_dv high on entry to a WAIT state counts as already risen; the next falling edge completes the wait.
- No arithmetic on samples: data passes bit-exact, with no scaling or sign change.

Test Plan:
- Reset: hold rst_n=0 with clocks running, release -> busy=0, start_FFT=0, En_FFT1=1, FFT_xn_re=0, err=0.
- Nominal frame:
  - Stimulus: capture_go; 256 adc_valid strobes with adc1=k, adc2=-k; fft_rfd always 1; model the dv pulse at 300 cycles after start_FFT, lasting 256 cycles.
  - Required: exactly two start_FFT pulses. FFT_xn_re sequence 0..255 with En_FFT1=1, then 0,-1..-255 with En_FFT1=0. En_FFT1 is constant during each dv window. One frame_done pulse.
- fft_rfd gaps and sparse capture:
  - Stimulus: fft_rfd toggles 1,0,0 repeatedly; adc_valid every 5th cycle.
  - Required: each sample is presented exactly once, in order, during accept cycles only.
- Timeout: fft_dv held 0 after LOAD1 -> err=1 after 4096 cycles, return to IDLE, no frame_done, no second start_FFT.
- Busy request: capture_go pulsed during LOAD2 -> err=1; the current frame completes normally with frame_done.
- Reset mid-frame: rst_n=0 during LOAD1 at sample 100 -> outputs return to reset values immediately; a fresh capture_go then runs a complete frame correctly.
